// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding ibus request at a time,
// handles EX redirects and stall[0]. Optional misaligned-redirect trap: IFU_MISALIGN_TRAP_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        br,
   input  logic [31:0] br_addr,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ack,
   input  logic [31:0] ibus_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq_if,
   output logic        if_err
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic [31:0] r_shadow;
   logic        r_err;

   logic [31:0] w_br_tgt;
   logic        w_br_bad;
   logic        w_unused_stall;

   assign w_unused_stall = &{1'b0, stall[5:1]};

`ifdef IFU_MISALIGN_TRAP_EN
   assign w_br_tgt = br_addr;
   assign w_br_bad = br && (br_addr[1:0] != 2'b00);
`else
   logic w_unused_br_lsb;
   assign w_br_tgt        = {br_addr[31:2], 2'b00};
   assign w_br_bad        = 1'b0;
   assign w_unused_br_lsb = &{1'b0, br_addr[1:0]};
`endif

   // Bus and presentation outputs depend only on state, rst and ibus_ack.
   always_comb begin
      ibus_req    = 1'b0;
      ibus_addr   = r_pc;
      if_pc       = r_pc;
      if_inst     = 32'h0;
      stallreq_if = 1'b0;
      if (rst) begin
         ibus_addr = RESET_PC;
         if_pc     = RESET_PC;
      end else begin
         case (r_state)
            S_REQ: begin
               if (r_err) begin
                  stallreq_if = 1'b1;
               end else begin
                  ibus_req = 1'b1;
                  if (ibus_ack) if_inst = ibus_rdata;
                  else          stallreq_if = 1'b1;
               end
            end
            S_HOLD: if_inst = r_buf;
            S_DRAIN: begin
               ibus_req    = 1'b1;
               ibus_addr   = r_shadow;
               stallreq_if = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign if_err = r_err && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_REQ;
         r_pc     <= RESET_PC;
         r_buf    <= 32'h0;
         r_shadow <= RESET_PC;
         r_err    <= 1'b0;
      end else begin
         if (w_br_bad) r_err <= 1'b1;
         case (r_state)
            S_REQ: begin
               // A trapped fetch unit stays here with no request on the bus.
               if (!r_err) begin
                  if (br) begin
                     r_pc <= w_br_tgt;
                     if (!ibus_ack) begin
                        r_shadow <= r_pc;
                        r_state  <= S_DRAIN;
                     end
                  end else if (ibus_ack) begin
                     if (!stall[0]) begin
                        r_pc <= r_pc + 32'd4;
                     end else begin
                        r_buf   <= ibus_rdata;
                        r_state <= S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (br) begin
                  r_pc    <= w_br_tgt;
                  r_state <= S_REQ;
               end else if (!stall[0]) begin
                  r_pc    <= r_pc + 32'd4;
                  r_state <= S_REQ;
               end
            end
            S_DRAIN: begin
               // The stale request must complete before the target is fetched.
               if (br)       r_pc    <= w_br_tgt;
               if (ibus_ack) r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that drives the IF side of the IF/ID pipeline register with `if_pc`/`if_inst`. It owns the program counter and issues single-outstanding requests on the instruction bus. It applies branch redirects from EX and raises `stallreq_if` to the pipeline controller while an instruction is not yet available. It honours the controller's `stall[5:0]` vector with the same bit meanings as the rest of the pipeline: bit 0 = PC, bit 1 = IF.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; reset rst, synchronous, active-high; clock clk.
- `stall`  in  6  controller stall vector; only `stall[0]` (hold PC) is used.
- `br`  in  1  branch/jump taken this cycle.
- `br_addr`  in  32  redirect target; valid when `br`=1.
- `ibus_req`  out  1  instruction bus request.
- `ibus_addr`  out  32  request address.
- `ibus_ack`  in  1  request completed; `ibus_rdata` valid. May be asserted in the same cycle as `ibus_req` (zero-wait).
- `ibus_rdata`  in  32  fetched instruction word.
- `if_pc`  out  32  PC of the presented instruction.
- `if_inst`  out  32  presented instruction; 0 when none is valid.
- `stallreq_if`  out  1  stall request to the controller.
- `if_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registered state: `pc[31:0]`, `buf[31:0]`, FSM state.
- FSM states:
  - **REQ**
    - Drives `ibus_req`=1, `ibus_addr`=`pc`.
    - On `ibus_ack`, it presents `if_inst`=`ibus_rdata` combinationally.
      - If `!stall[0]`: `pc`<=`pc`+4 and the state stays REQ.
      - Else: `buf`<=`ibus_rdata` and the state goes to HOLD.
    - Without ack: `stallreq_if`=1 and `if_inst`=0.
  - **HOLD**
    - Drives `ibus_req`=0 and presents `if_inst`=`buf`, `if_pc`=`pc`.
    - When `!stall[0]`: `pc`<=`pc`+4 and the state goes to REQ.
  - **DRAIN**
    - Entered on `br` while a REQ transaction is outstanding (no ack that cycle). `pc`<=`br_addr`.
    - `ibus_req`=1 and `ibus_addr` hold the old address, which is kept in a shadow register.
    - `stallreq_if`=1 and `if_inst`=0.
    - On `ibus_ack`, the returned data is discarded and the state goes to REQ.
- Bus rule: once `ibus_req` rises, `ibus_req` and `ibus_addr` are held stable until `ibus_ack`. A request is never withdrawn except by `rst`.
- Branch handling:
  - `br` has priority over `stall[0]` in every state.
  - REQ with ack, or HOLD: the instruction is discarded, `pc`<=`br_addr`, next state REQ.
  - REQ without ack: next state DRAIN.
  - DRAIN with a further `br`: the target is updated to the newest `br_addr`.
- PC arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- `if_pc` always equals `pc`, except in DRAIN, where it equals the new target.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=REQ.
  - While `rst`=1: `ibus_req`=0, `ibus_addr`=`RESET_PC`, `if_pc`=`RESET_PC`, `if_inst`=0, `stallreq_if`=0, `if_err`=0.
- First `ibus_req` is issued in the first cycle with `rst`=0.
- Zero-wait memory gives 1 instruction per cycle, with no stall request.
- A memory with N wait cycles gives N cycles of `stallreq_if`=1 per instruction.
- Branch penalty from the fetch side:
  - 0 extra cycles with zero-wait memory. The target is requested in the cycle after `br`.
  - Plus the remaining wait of any drained transaction.
- `rst` asserted mid-transaction abandons it. `ibus_req` drops in the reset cycle.
- `stallreq_if`, `if_inst` and `if_pc` are combinational from state and `ibus_ack`. No combinational path exists from `stall` or `br` to `ibus_req`.

## Configuration
- `IFU_MISALIGN_TRAP_EN`
  - Defined: a `br` with `br_addr[1:0]`!=0 sets `if_err`=1, which is sticky until `rst`. The FSM then parks in REQ without issuing requests: `ibus_req`=0, `stallreq_if`=1, `if_inst`=0.
  - Undefined: `br_addr[1:0]` is forced to 2'b00 on load, and `if_err` is tied to 0.

## Test plan
- Zero-wait memory, `ibus_ack`=1 every cycle, `RESET_PC`=0, rst released -> `if_pc` = 0,4,8,12 on consecutive cycles; `stallreq_if` stays 0.
- 2-wait memory -> each address is held for 3 cycles, with `stallreq_if`=1 for 2 cycles and then `if_inst`=rdata, `if_pc` stepping by 4.
- `stall[0]`=1 for 3 cycles at `pc`=8 -> state HOLD, `ibus_req`=0, `if_inst`=buffered word; on release the next request goes to 12.
- `br`=1 with `br_addr`=0x100 while the request to 0x20 is pending (2-wait):
  - `ibus_addr` stays 0x20 until ack and that data is discarded.
  - The next request is to 0x100, and `if_inst` stays 0 throughout the drain.
- `br` and `stall[0]` both asserted in HOLD -> `br` wins and the next request is `br_addr`. Separately, `pc`=32'hFFFF_FFFC advances -> next `pc`=0.
- `br_addr`=0x102:
  - With `IFU_MISALIGN_TRAP_EN` -> `if_err`=1 and no further `ibus_req` until `rst`.
  - Without it -> the fetch goes to 0x100.
